// File: rtl/mulalu.sv
// mulalu - iterative 32-bit multiply/divide unit feeding the HI/LO registers.
//
// Takes a MULT/MULTU/DIV/DIVU request from the EX-stage ALU. It computes one
// bit per cycle over 32 BUSY cycles. The result is returned as a single-cycle
// HI/LO write in DONE. The latency is fixed at 34 EX cycles for every op and
// every operand value.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous cancel of the instruction in EX
//   mulalu_func        FUNC_MUL / FUNC_DIV / 0 (no request)
//   mulalu_sign        1 = signed (MULT/DIV), 0 = unsigned
//   source_a           multiplicand / dividend (rs)
//   source_b           multiplier / divisor (rt)
//   stall              holds IF/ID/EX while high (combinational)
//   hi_write(_data)    HI strobe; data is product[63:32] or the remainder
//   lo_write(_data)    LO strobe; data is product[31:0] or the quotient
module mulalu #(
  localparam int             W_DATA   = 32,
  localparam int             W_FUNC   = 5,
  localparam logic [W_FUNC-1:0] FUNC_MUL = 5'd1,
  localparam logic [W_FUNC-1:0] FUNC_DIV = 5'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [W_FUNC-1:0] mulalu_func,
  input  logic              mulalu_sign,
  input  logic [W_DATA-1:0] source_a,
  input  logic [W_DATA-1:0] source_b,
  output logic              stall,
  output logic              hi_write,
  output logic [W_DATA-1:0] hi_write_data,
  output logic              lo_write,
  output logic [W_DATA-1:0] lo_write_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_cnt;
  logic              r_is_div;
  logic              r_neg_q;    // negate product / quotient
  logic              r_neg_r;    // negate remainder
  // Shared working registers:
  //   mul: {r_hi, r_lo} is the accumulator, r_lo starts as the multiplier
  //        and r_b is the multiplicand
  //   div: r_hi is the partial remainder, r_lo shifts the dividend out and
  //        the quotient in, and r_b is the divisor
  logic [W_DATA-1:0] r_hi, r_lo, r_b;
  logic [W_DATA-1:0] r_hi_out, r_lo_out;

  logic              w_req;
  logic [W_DATA-1:0] w_a_mag, w_b_mag;
  logic [W_DATA:0]   w_add;
  logic [W_DATA:0]   w_part;
  logic [W_DATA+1:0] w_sub;
  logic [W_DATA-1:0] w_hi_step, w_lo_step;
  logic [2*W_DATA-1:0] w_prod_neg;
  logic [W_DATA-1:0] w_hi_fin, w_lo_fin;

  assign w_req   = ((mulalu_func == FUNC_MUL) || (mulalu_func == FUNC_DIV)) && !flush;
  assign w_a_mag = (mulalu_sign && source_a[W_DATA-1]) ? -source_a : source_a;
  assign w_b_mag = (mulalu_sign && source_b[W_DATA-1]) ? -source_b : source_b;

  // One iteration of shift-add or restoring division.
  always_comb begin
    w_add     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_part    = {r_hi, r_lo[W_DATA-1]};
    // The extra top bit is the borrow. When no borrow occurs the difference
    // is smaller than the divisor, so it fits in 32 bits. With a zero divisor
    // the borrow never fires. Every quotient bit is then 1, and the dividend
    // shifts unchanged into the remainder.
    w_sub     = {1'b0, w_part} - {2'b00, r_b};
    w_hi_step = '0;
    w_lo_step = '0;
    if (r_is_div) begin
      w_hi_step = w_sub[W_DATA+1] ? w_part[W_DATA-1:0] : w_sub[W_DATA-1:0];
      w_lo_step = {r_lo[W_DATA-2:0], ~w_sub[W_DATA+1]};
    end else begin
      w_hi_step = w_add[W_DATA:1];
      w_lo_step = {w_add[0], r_lo[W_DATA-1:1]};
    end
  end

  // Sign correction on the final step. Magnitude arithmetic wraps, so
  // 0x80000000 / -1 yields 0x80000000 with no overflow indication.
  always_comb begin
    w_prod_neg = -{w_hi_step, w_lo_step};
    w_hi_fin   = w_hi_step;
    w_lo_fin   = w_lo_step;
    if (r_is_div) begin
      if (r_neg_r) w_hi_fin = -w_hi_step;
      if (r_neg_q) w_lo_fin = -w_lo_step;
    end else if (r_neg_q) begin
      w_hi_fin = w_prod_neg[2*W_DATA-1:W_DATA];
      w_lo_fin = w_prod_neg[W_DATA-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req) w_state_nxt = BUSY;
      BUSY:    if (flush) w_state_nxt = IDLE;
               else if (r_cnt == 5'd31) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_hi_out <= '0;
      r_lo_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (w_req) begin
          r_is_div <= (mulalu_func == FUNC_DIV);
          r_neg_q  <= mulalu_sign && (source_a[W_DATA-1] ^ source_b[W_DATA-1]);
          r_neg_r  <= mulalu_sign && source_a[W_DATA-1];
          r_hi     <= '0;
          r_cnt    <= '0;
          if (mulalu_func == FUNC_DIV) begin
            r_lo <= w_a_mag;
            r_b  <= w_b_mag;
          end else begin
            r_lo <= w_b_mag;
            r_b  <= w_a_mag;
          end
        end
        BUSY: begin
          r_hi  <= w_hi_step;
          r_lo  <= w_lo_step;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31 && !flush) begin
            r_hi_out <= w_hi_fin;
            r_lo_out <= w_lo_fin;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by rst_n so that every output reads 0 while reset is held,
  // even when a request is present on the inputs.
  assign stall         = rst_n && (((r_state == IDLE) && w_req) || (r_state == BUSY));
  assign hi_write      = (r_state == DONE) && !flush;
  assign lo_write      = (r_state == DONE) && !flush;
  assign hi_write_data = r_hi_out;
  assign lo_write_data = r_lo_out;

endmodule

// File: tb/tb_mulalu.sv
module tb_mulalu;
  localparam logic [4:0] F_NONE = 5'd0;
  localparam logic [4:0] F_MUL  = 5'd1;
  localparam logic [4:0] F_DIV  = 5'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [4:0]  mulalu_func;
  logic        mulalu_sign;
  logic [31:0] source_a, source_b;
  logic        stall, hi_write, lo_write;
  logic [31:0] hi_write_data, lo_write_data;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int last_done = 0;

  mulalu dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mulalu_func(mulalu_func), .mulalu_sign(mulalu_sign),
    .source_a(source_a), .source_b(source_b),
    .stall(stall),
    .hi_write(hi_write), .hi_write_data(hi_write_data),
    .lo_write(lo_write), .lo_write_data(lo_write_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Applies the request (cycle 0), follows the op to
  // DONE, and checks latency, stall, data and strobes. Returns at the negedge
  // of the cycle after DONE (IDLE), so a following call issues back-to-back.
  task automatic do_op(input string tag, input logic [4:0] f, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int n;
    int bad;
    mulalu_func = f; mulalu_sign = s; source_a = a; source_b = b;
    #1 chk({tag, " stall0"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    mulalu_func = F_NONE;
    source_a = $urandom;   // operands must be ignored after acceptance
    source_b = $urandom;
    n = 0; bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hi_write && !stall) bad++;
    end while (!hi_write && n < 40);
    last_done = cyc;
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " busy_stall_gaps"}, 64'(bad), 64'd0);
    chk({tag, " done_stall"}, 64'(stall), 64'd0);
    chk({tag, " done_strobes"}, {62'd0, hi_write, lo_write}, 64'd3);
    chk({tag, " hi"}, 64'(hi_write_data), 64'(eh));
    chk({tag, " lo"}, 64'(lo_write_data), 64'(el));
    @(negedge clk);
    chk({tag, " post_strobes"}, {62'd0, hi_write, lo_write}, 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    int first_done;
    rst_n = 1'b0; flush = 1'b0; mulalu_func = F_NONE; mulalu_sign = 1'b0;
    source_a = '0; source_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {29'd0, stall, hi_write, lo_write, hi_write_data},
        64'd0);
    chk("reset_lo_data", 64'(lo_write_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req_stall", 64'(stall), 64'd0);

    do_op("multu_max", F_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_op("mult_neg3x7", F_MUL, 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("mult_minsq", F_MUL, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    do_op("div_m7_2", F_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_7_m2", F_DIV, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    do_op("divu_7_2", F_DIV, 1'b0, 32'd7, 32'd2, 32'd1, 32'd3);
    do_op("divu_5_0", F_DIV, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    do_op("div_min_m1", F_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

    // Back-to-back: second request issued in the IDLE cycle right after DONE.
    do_op("b2b_multu", F_MUL, 1'b0, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780);
    first_done = last_done;
    do_op("b2b_divu", F_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    chk("b2b_spacing", 64'(last_done - first_done), 64'd34);

    // Flush in BUSY cycle 10.
    mulalu_func = F_MUL; mulalu_sign = 1'b0; source_a = 32'd3; source_b = 32'd5;
    @(posedge clk);
    #1 mulalu_func = F_NONE;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_busy_stall_before", 64'(stall), 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_idle_stall", 64'(stall), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (hi_write || lo_write || stall) seen++;
    end
    chk("flush_busy_no_strobe", 64'(seen), 64'd0);

    // Flush in the DONE cycle.
    mulalu_func = F_DIV; mulalu_sign = 1'b0; source_a = 32'd9; source_b = 32'd3;
    @(posedge clk);
    #1 mulalu_func = F_NONE;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 40);
    chk("flush_done_latency", 64'(n), 64'd33);
    flush = 1'b1;
    #1 chk("flush_done_strobes", {62'd0, hi_write, lo_write}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_done_after", {61'd0, stall, hi_write, lo_write}, 64'd0);

    // Reset mid-BUSY (the data registers are nonzero from earlier ops).
    mulalu_func = F_MUL; mulalu_sign = 1'b1; source_a = 32'd11; source_b = 32'd13;
    @(posedge clk);
    #1 mulalu_func = F_NONE;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_busy_ctrl", {61'd0, stall, hi_write, lo_write}, 64'd0);
    chk("rst_busy_data", {hi_write_data, lo_write_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_reset_mult", F_MUL, 1'b1, 32'd11, 32'hFFFFFFF3, 32'hFFFFFFFF, 32'hFFFFFF71);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
